// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and defaults for the memory-access stage
package mem_stage_pkg;

    localparam logic [7:0] SP_INIT_DEF     = 8'hFF;
    localparam logic [7:0] STACK_FLOOR_DEF = 8'hC0;

    typedef enum logic [1:0] {
        SRC_ALU   = 2'b00,
        SRC_WDATA = 2'b01,
        SRC_SP    = 2'b10,
        SRC_RSVD  = 2'b11
    } mem_src_e;

    typedef enum logic [1:0] {
        PUSH_WDATA = 2'b00,
        PUSH_ALU   = 2'b01,
        PUSH_PC    = 2'b10,
        PUSH_FLAGS = 2'b11
    } push_sel_e;

    function automatic logic [7:0] select_addr(
        input mem_src_e   src,
        input logic [7:0] alu_result,
        input logic [7:0] write_data,
        input logic [7:0] sp
    );
        case (src)
            SRC_WDATA: select_addr = write_data;
            SRC_SP:    select_addr = sp;
            default:   select_addr = alu_result;
        endcase
    endfunction

    function automatic logic [7:0] select_push(
        input push_sel_e  sel,
        input logic [7:0] write_data,
        input logic [7:0] alu_result,
        input logic [7:0] pc_ret,
        input logic [3:0] flags
    );
        case (sel)
            PUSH_ALU:   select_push = alu_result;
            PUSH_PC:    select_push = pc_ret;
            PUSH_FLAGS: select_push = {4'b0000, flags};
            default:    select_push = write_data;
        endcase
    endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// rtl/stack_pointer_unit.sv - stack pointer register, push/pop qualification and sticky guard flags
// Guard checks are active only when STACK_GUARD_EN is defined.
module stack_pointer_unit
    import mem_stage_pkg::*;
#(
    parameter logic [7:0] SP_INIT     = SP_INIT_DEF,
    parameter logic [7:0] STACK_FLOOR = STACK_FLOOR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       push_req,
    input  logic       pop_req,
    output logic [7:0] sp,
    output logic       push_ok,
    output logic       pop_ok,
    output logic       pop_blocked,
    output logic       stack_ovf,
    output logic       stack_unf
);

`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic legal;
    logic at_floor;
    logic at_top;
    logic push_blocked;

    // Simultaneous push and pop is illegal and touches nothing.
    assign legal        = !stall && !(push_req && pop_req);
    assign at_floor     = (sp == (STACK_FLOOR - 8'd1));
    assign at_top       = (sp == SP_INIT);
    assign push_blocked = GUARD && legal && push_req && at_floor;
    assign pop_blocked  = GUARD && legal && pop_req && at_top;
    assign push_ok      = legal && push_req && !push_blocked;
    assign pop_ok       = legal && pop_req && !pop_blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= SP_INIT;
        end else if (push_ok) begin
            sp <= sp - 8'd1;
        end else if (pop_ok) begin
            sp <= sp + 8'd1;
        end
    end

`ifdef STACK_GUARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (push_blocked) stack_ovf <= 1'b1;
            if (pop_blocked)  stack_unf <= 1'b1;
        end
    end
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: data memory, loads/stores, stack push/pop with registered WB outputs
// Optional stack window guard enabled by defining STACK_GUARD_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] SP_INIT     = SP_INIT_DEF,
    parameter logic [7:0] STACK_FLOOR = STACK_FLOOR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_stall,
    input  logic       mem_mem_read,
    input  logic       mem_mem_write,
    input  logic [7:0] mem_alu_result,
    input  logic [7:0] mem_write_data,
    input  logic [1:0] mem_src_mem,
    input  logic [1:0] stack_push_mux_mem,
    input  logic       stack_pop_mux_mem,
    input  logic       stack_push_mem,
    input  logic       stack_pop_mem,
    input  logic [7:0] mem_pc_ret,
    input  logic [3:0] mem_flags,
    output logic [7:0] wb_read_data,
    output logic [7:0] wb_ret_pc,
    output logic       wb_ret_valid,
    output logic [7:0] sp,
    output logic       stack_ovf,
    output logic       stack_unf
);

    logic [7:0] mem [2**ADDR_W];

    logic       push_ok;
    logic       pop_ok;
    logic       pop_blocked;
    logic       stack_op;
    logic       store_en;
    logic       load_en;
    logic       wr_en;
    logic [7:0] data_addr;
    logic [7:0] push_data;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] pop_addr;

    stack_pointer_unit #(
        .SP_INIT     (SP_INIT),
        .STACK_FLOOR (STACK_FLOOR)
    ) u_spu (
        .clk         (clk),
        .rst         (rst),
        .stall       (mem_stall),
        .push_req    (stack_push_mem),
        .pop_req     (stack_pop_mem),
        .sp          (sp),
        .push_ok     (push_ok),
        .pop_ok      (pop_ok),
        .pop_blocked (pop_blocked),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    // Any stack request (even an illegal or guarded one) masks ordinary loads and stores.
    assign stack_op  = stack_push_mem || stack_pop_mem;
    assign store_en  = !mem_stall && mem_mem_write && !stack_op;
    assign load_en   = !mem_stall && mem_mem_read && !stack_op;
    assign data_addr = select_addr(mem_src_e'(mem_src_mem), mem_alu_result, mem_write_data, sp);
    assign push_data = select_push(push_sel_e'(stack_push_mux_mem), mem_write_data,
                                   mem_alu_result, mem_pc_ret, mem_flags);
    assign pop_addr  = sp + 8'd1;

    // A write pending when reset arrives is dropped.
    assign wr_en   = (push_ok || store_en) && !rst;
    assign wr_addr = push_ok ? sp : data_addr;
    assign wr_data = push_ok ? push_data : mem_write_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ADDR_W'(wr_addr)] <= wr_data;
        end
    end

    // Reading in the same edge as the write gives read-before-write for store+load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_read_data <= 8'h00;
            wb_ret_pc    <= 8'h00;
            wb_ret_valid <= 1'b0;
        end else begin
            wb_ret_valid <= 1'b0;
            if (pop_ok) begin
                wb_read_data <= mem[ADDR_W'(pop_addr)];
                if (stack_pop_mux_mem) begin
                    wb_ret_pc    <= mem[ADDR_W'(pop_addr)];
                    wb_ret_valid <= 1'b1;
                end
            end else if (pop_blocked) begin
                wb_read_data <= 8'h00;
            end else if (load_en) begin
                wb_read_data <= mem[ADDR_W'(data_addr)];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with a behavioural stack/memory model
module tb_mem_stage;

`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_stall, mem_mem_read, mem_mem_write;
    logic [7:0] mem_alu_result, mem_write_data, mem_pc_ret;
    logic [1:0] mem_src_mem, stack_push_mux_mem;
    logic       stack_pop_mux_mem, stack_push_mem, stack_pop_mem;
    logic [3:0] mem_flags;
    logic [7:0] wb_read_data, wb_ret_pc, sp;
    logic       wb_ret_valid, stack_ovf, stack_unf;

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .mem_stall          (mem_stall),
        .mem_mem_read       (mem_mem_read),
        .mem_mem_write      (mem_mem_write),
        .mem_alu_result     (mem_alu_result),
        .mem_write_data     (mem_write_data),
        .mem_src_mem        (mem_src_mem),
        .stack_push_mux_mem (stack_push_mux_mem),
        .stack_pop_mux_mem  (stack_pop_mux_mem),
        .stack_push_mem     (stack_push_mem),
        .stack_pop_mem      (stack_pop_mem),
        .mem_pc_ret         (mem_pc_ret),
        .mem_flags          (mem_flags),
        .wb_read_data       (wb_read_data),
        .wb_ret_pc          (wb_ret_pc),
        .wb_ret_valid       (wb_ret_valid),
        .sp                 (sp),
        .stack_ovf          (stack_ovf),
        .stack_unf          (stack_unf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] m_sp, m_rd, m_ret;
    bit         m_rd_known, m_valid, m_ovf, m_unf;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && !rst) begin
            cmp("model_sp", sp, m_sp);
            if (m_rd_known) cmp("model_rd", wb_read_data, m_rd);
            cmp("model_ret_valid", {7'b0, wb_ret_valid}, {7'b0, m_valid});
            cmp("model_ret_pc", wb_ret_pc, m_ret);
            cmp("model_ovf", {7'b0, stack_ovf}, {7'b0, m_ovf});
            cmp("model_unf", {7'b0, stack_unf}, {7'b0, m_unf});
        end
    end

    task automatic idle();
        mem_stall = 0; mem_mem_read = 0; mem_mem_write = 0;
        mem_alu_result = 0; mem_write_data = 0; mem_src_mem = 0;
        stack_push_mux_mem = 0; stack_pop_mux_mem = 0;
        stack_push_mem = 0; stack_pop_mem = 0; mem_pc_ret = 0; mem_flags = 0;
    endtask

    task automatic model_reset();
        m_sp = 8'hFF; m_rd = 0; m_rd_known = 1; m_ret = 0;
        m_valid = 0; m_ovf = 0; m_unf = 0;
    endtask

    // One clock of the stage, applying the behavioural rules to the model.
    task automatic tick();
        logic [7:0] a, pd;
        @(posedge clk);
        case (mem_src_mem)
            2'd1:    a = mem_write_data;
            2'd2:    a = m_sp;
            default: a = mem_alu_result;
        endcase
        case (stack_push_mux_mem)
            2'd1:    pd = mem_alu_result;
            2'd2:    pd = mem_pc_ret;
            2'd3:    pd = {4'h0, mem_flags};
            default: pd = mem_write_data;
        endcase
        m_valid = 0;
        if (!rst && !mem_stall) begin
            if (stack_push_mem && stack_pop_mem) begin
                m_valid = 0;
            end else if (stack_push_mem) begin
                if (GUARD && m_sp == 8'hBF) m_ovf = 1;
                else begin
                    m_mem[m_sp] = pd; m_known[m_sp] = 1; m_sp = m_sp - 8'd1;
                end
            end else if (stack_pop_mem) begin
                if (GUARD && m_sp == 8'hFF) begin
                    m_unf = 1; m_rd = 0; m_rd_known = 1;
                end else begin
                    m_sp = m_sp + 8'd1;
                    m_rd = m_mem[m_sp]; m_rd_known = m_known[m_sp];
                    if (stack_pop_mux_mem) begin m_ret = m_rd; m_valid = 1; end
                end
            end else begin
                if (mem_mem_read) begin m_rd = m_mem[a]; m_rd_known = m_known[a]; end
                if (mem_mem_write) begin m_mem[a] = mem_write_data; m_known[a] = 1; end
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        check_en = 0;
        rst = 1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check_en = 1;
    endtask

    task automatic push_op(input logic [1:0] sel, input logic [7:0] wd, input logic [7:0] alu,
                           input logic [7:0] pc, input logic [3:0] fl);
        idle();
        stack_push_mem = 1; stack_push_mux_mem = sel;
        mem_write_data = wd; mem_alu_result = alu; mem_pc_ret = pc; mem_flags = fl;
        tick();
    endtask

    task automatic pop_op(input logic ret);
        idle();
        stack_pop_mem = 1; stack_pop_mux_mem = ret;
        tick();
    endtask

    task automatic store_op(input logic [1:0] src, input logic [7:0] alu, input logic [7:0] wd);
        idle();
        mem_mem_write = 1; mem_src_mem = src; mem_alu_result = alu; mem_write_data = wd;
        tick();
    endtask

    task automatic load_op(input logic [1:0] src, input logic [7:0] alu, input logic [7:0] wd);
        idle();
        mem_mem_read = 1; mem_src_mem = src; mem_alu_result = alu; mem_write_data = wd;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin m_mem[i] = 0; m_known[i] = 0; end
        idle();
        do_reset();
        cmp("reset_sp", sp, 8'hFF);
        cmp("reset_rd", wb_read_data, 8'h00);
        cmp("reset_ret_pc", wb_ret_pc, 8'h00);
        cmp("reset_ret_valid", {7'b0, wb_ret_valid}, 8'h00);
        cmp("reset_flags", {6'b0, stack_ovf, stack_unf}, 8'h00);

        store_op(2'b00, 8'h10, 8'h5A);
        load_op(2'b00, 8'h10, 8'h00);
        cmp("load_5a", wb_read_data, 8'h5A);

        push_op(2'b00, 8'h33, 8'h00, 8'h00, 4'h0);
        cmp("push_sp", sp, 8'hFE);
        pop_op(1'b0);
        cmp("pop_sp", sp, 8'hFF);
        cmp("pop_data", wb_read_data, 8'h33);

        push_op(2'b10, 8'h00, 8'h00, 8'h42, 4'h0);
        pop_op(1'b1);
        cmp("ret_pc", wb_ret_pc, 8'h42);
        cmp("ret_valid_hi", {7'b0, wb_ret_valid}, 8'h01);
        idle(); tick();
        cmp("ret_valid_lo", {7'b0, wb_ret_valid}, 8'h00);

        push_op(2'b00, 8'h11, 8'h00, 8'h00, 4'h0);
        idle();
        stack_push_mem = 1; stack_pop_mem = 1; stack_pop_mux_mem = 1;
        mem_write_data = 8'h99; mem_mem_write = 1; mem_alu_result = 8'h10;
        tick();
        cmp("pushpop_sp", sp, 8'hFE);
        cmp("pushpop_valid", {7'b0, wb_ret_valid}, 8'h00);
        pop_op(1'b0);
        cmp("pushpop_mem", wb_read_data, 8'h11);
        load_op(2'b00, 8'h10, 8'h00);
        cmp("pushpop_nostore", wb_read_data, 8'h5A);

        idle();
        mem_stall = 1; stack_push_mem = 1; mem_write_data = 8'h66;
        tick();
        cmp("stall_sp", sp, 8'hFF);
        mem_stall = 0;
        tick();
        cmp("unstall_sp", sp, 8'hFE);
        idle();
        mem_stall = 1; stack_pop_mem = 1; stack_pop_mux_mem = 1;
        tick();
        cmp("stall_pop_valid", {7'b0, wb_ret_valid}, 8'h00);
        pop_op(1'b0);
        cmp("stall_push_data", wb_read_data, 8'h66);

        push_op(2'b01, 8'h00, 8'h3C, 8'h00, 4'h0);
        push_op(2'b11, 8'h00, 8'h00, 8'h00, 4'hA);
        pop_op(1'b0);
        cmp("flags_push", wb_read_data, 8'h0A);
        pop_op(1'b0);
        cmp("alu_push", wb_read_data, 8'h3C);

        store_op(2'b00, 8'h20, 8'h11);
        idle();
        mem_mem_write = 1; mem_mem_read = 1; mem_alu_result = 8'h20; mem_write_data = 8'h99;
        tick();
        cmp("rbw_old", wb_read_data, 8'h11);
        load_op(2'b11, 8'h20, 8'h00);
        cmp("rbw_new", wb_read_data, 8'h99);
        store_op(2'b01, 8'h00, 8'h44);
        load_op(2'b01, 8'h00, 8'h44);
        cmp("indirect", wb_read_data, 8'h44);
        store_op(2'b10, 8'h00, 8'hD2);
        load_op(2'b00, 8'hFF, 8'h00);
        cmp("sp_addr", wb_read_data, 8'hD2);

        push_op(2'b00, 8'h77, 8'h00, 8'h00, 4'h0);
        idle();
        mem_mem_write = 1; mem_alu_result = 8'h20; mem_write_data = 8'hEE;
        #1 rst = 1;
        check_en = 0;
        #1;
        cmp("async_rst_sp", sp, 8'hFF);
        cmp("async_rst_rd", wb_read_data, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check_en = 1;
        load_op(2'b00, 8'h20, 8'h00);
        cmp("lost_write", wb_read_data, 8'h99);

        do_reset();
`ifdef STACK_GUARD_EN
        pop_op(1'b1);
        cmp("unf_flag", {7'b0, stack_unf}, 8'h01);
        cmp("unf_sp", sp, 8'hFF);
        cmp("unf_rd", wb_read_data, 8'h00);
`else
        store_op(2'b00, 8'h00, 8'hE7);
        pop_op(1'b0);
        cmp("wrap_sp", sp, 8'h00);
        cmp("wrap_rd", wb_read_data, 8'hE7);
        do_reset();
`endif
        for (int i = 0; i < 64; i++) push_op(2'b00, 8'(i), 8'h00, 8'h00, 4'h0);
        cmp("push64_sp", sp, 8'hBF);
        push_op(2'b00, 8'h40, 8'h00, 8'h00, 4'h0);
        cmp("push65_sp", sp, GUARD ? 8'hBF : 8'hBE);
        cmp("push65_ovf", {7'b0, stack_ovf}, GUARD ? 8'h01 : 8'h00);
        pop_op(1'b0);
        cmp("push65_pop", wb_read_data, GUARD ? 8'h3F : 8'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
